// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential HACK-style ALU.
package alu_pkg;

   localparam logic [1:0] MODE_HACK  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_MUL   = 2'b10;

   localparam logic [1:0] SH_SHL = 2'b00;
   localparam logic [1:0] SH_SHR = 2'b01;
   localparam logic [1:0] SH_SAR = 2'b10;
   localparam logic [1:0] SH_ROL = 2'b11;

   localparam int CTL_ZX = 5;
   localparam int CTL_NX = 4;
   localparam int CTL_ZY = 3;
   localparam int CTL_NY = 2;
   localparam int CTL_F  = 1;
   localparam int CTL_NO = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational six-stage HACK ALU function at arbitrary width.
module hack_alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [5:0]       ctl_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] xz, xn, yz, yn, fr;

   always_comb begin
      xz    = ctl_i[CTL_ZX] ? '0 : x_i;
      xn    = ctl_i[CTL_NX] ? ~xz : xz;
      yz    = ctl_i[CTL_ZY] ? '0 : y_i;
      yn    = ctl_i[CTL_NY] ? ~yz : yz;
      fr    = ctl_i[CTL_F] ? (xn + yn) : (xn & yn);
      out_o = ctl_i[CTL_NO] ? ~fr : fr;
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle HACK/shift ops, iterative shift-add multiply,
// registered result held under valid/ready.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [5:0]       ctl,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
   logic [WIDTH-1:0]   mplr_q;
   logic [WIDTH-1:0]   out_q;
   logic               zr_q, ng_q, ovf_q;

   logic [WIDTH-1:0]   hack_res, shf_res, single_res;
   logic [2*WIDTH-1:0] rol_w;
   logic [CNT_W-1:0]   amt;
   logic               accept, is_mul;

   hack_alu_core #(.WIDTH(WIDTH)) u_hack (
      .x_i   (x),
      .y_i   (y),
      .ctl_i (ctl),
      .out_o (hack_res)
   );

   // Rotate done on a doubled word so amount 0 needs no special case.
   always_comb begin
      amt   = y[CNT_W-1:0];
      rol_w = {x, x} << amt;
      case (ctl[1:0])
         SH_SHL:  shf_res = x << amt;
         SH_SHR:  shf_res = x >> amt;
         SH_SAR:  shf_res = $unsigned($signed(x) >>> amt);
         default: shf_res = rol_w[2*WIDTH-1:WIDTH];
      endcase
      single_res = (mode == MODE_SHIFT) ? shf_res : hack_res;
   end

   assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = MUL_EN && (mode == MODE_MUL);
   assign acc_d    = acc_q + (mplr_q[0] ? mcand_q : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         zr_q    <= 1'b0;
         ng_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= BUSY;
                     cnt_q   <= '0;
                     mcand_q <= {{WIDTH{1'b0}}, x};
                     mplr_q  <= y;
                     acc_q   <= '0;
                  end else begin
                     state_q <= DONE;
                     out_q   <= single_res;
                     zr_q    <= (single_res == '0);
                     ng_q    <= single_res[WIDTH-1];
                     ovf_q   <= 1'b0;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               acc_q   <= acc_d;
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  out_q   <= acc_d[WIDTH-1:0];
                  zr_q    <= (acc_d[WIDTH-1:0] == '0);
                  ng_q    <= acc_d[WIDTH-1];
                  ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign zr        = zr_q;
   assign ng        = ng_q;
   assign ovf       = ovf_q;

endmodule
